bf_loop_stack: RTL and testbench

//  Parametrised LIFO for loop return addresses in the BF core, with a cached top-of-stack register.

---
 rtl/bf_pkg.sv | 15 +
 rtl/bf_stack_ram.sv | 26 ++
 rtl/bf_loop_stack.sv | 133 +++++++++++++
 tb/tb_bf_loop_stack.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bf_pkg.sv
// Shared constants and command encoding for the BF core loop stack.
package bf_pkg;

  localparam int BF_PC_W       = 11;
  localparam int BF_LOOP_DEPTH = 7;

  // Encoding matches {pop, push} so the branch-unit decoder can drive it directly.
  typedef enum logic [1:0] {
    STK_NOP  = 2'b00,
    STK_PUSH = 2'b01,
    STK_POP  = 2'b10,
    STK_REPL = 2'b11
  } stk_cmd_e;

endpackage

// File: rtl/bf_stack_ram.sv
// Simple dual-port distributed RAM: one synchronous write port, one asynchronous read port.
module bf_stack_ram #(
  parameter int WIDTH   = 11,
  parameter int ENTRIES = 127,
  parameter int AW      = 7
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [ENTRIES];

  // Write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/bf_loop_stack.sv
// Loop return-address LIFO with a registered top-of-stack, occupancy, and sticky error flags.
module bf_loop_stack
  import bf_pkg::*;
#(
  parameter int WIDTH = BF_PC_W,
  parameter int DEPTH = BF_LOOP_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic             err_clr,
  output logic [WIDTH-1:0] q,
  output logic             empty,
  output logic             full,
  output logic [DEPTH:0]   level,
  output logic             overflow,
  output logic             underflow
);

  localparam int             CAP      = 1 << DEPTH;
  localparam logic [DEPTH:0] LVL_ZERO = {(DEPTH+1){1'b0}};
  localparam logic [DEPTH:0] LVL_ONE  = (DEPTH+1)'(1);
  localparam logic [DEPTH:0] LVL_TWO  = (DEPTH+1)'(2);
  localparam logic [DEPTH:0] LVL_CAP  = (DEPTH+1)'(CAP);

  logic [WIDTH-1:0] q_q, q_d;
  logic [DEPTH:0]   level_q, level_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic             mem_we;
  logic [DEPTH:0]   lvl_m1, lvl_m2;
  logic [DEPTH-1:0] waddr, raddr;
  logic [WIDTH-1:0] rdata;
  logic             is_empty, is_full;
  stk_cmd_e         cmd;

  assign is_empty = (level_q == LVL_ZERO);
  assign is_full  = (level_q == LVL_CAP);
  assign cmd      = stk_cmd_e'({pop, push});

  // Addresses wrap harmlessly at low levels; they are only used when level makes them valid.
  assign lvl_m1 = level_q - LVL_ONE;
  assign lvl_m2 = level_q - LVL_TWO;
  assign waddr  = lvl_m1[DEPTH-1:0];
  assign raddr  = lvl_m2[DEPTH-1:0];

  bf_stack_ram #(
    .WIDTH   (WIDTH),
    .ENTRIES (CAP - 1),
    .AW      (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (mem_we),
    .waddr (waddr),
    .wdata (q_q),
    .raddr (raddr),
    .rdata (rdata)
  );

  // Next-state decode: flush beats push/pop; a new error beats err_clr.
  always_comb begin
    q_d     = q_q;
    level_d = level_q;
    ovf_d   = err_clr ? 1'b0 : ovf_q;
    unf_d   = err_clr ? 1'b0 : unf_q;
    mem_we  = 1'b0;
    if (flush) begin
      q_d     = {WIDTH{1'b0}};
      level_d = LVL_ZERO;
    end else begin
      case (cmd)
        STK_PUSH: begin
          if (is_full) begin
            ovf_d = 1'b1;
          end else begin
            mem_we  = !is_empty;
            q_d     = d;
            level_d = level_q + LVL_ONE;
          end
        end
        STK_POP: begin
          if (is_empty) begin
            unf_d = 1'b1;
          end else if (level_q == LVL_ONE) begin
            q_d     = {WIDTH{1'b0}};
            level_d = LVL_ZERO;
          end else begin
            q_d     = rdata;
            level_d = lvl_m1;
          end
        end
        STK_REPL: begin
          q_d = d;
          if (is_empty) begin
            level_d = LVL_ONE;
          end else begin
            level_d = level_q;
          end
        end
        default: begin
          q_d = q_q;
        end
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q     <= {WIDTH{1'b0}};
      level_q <= LVL_ZERO;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      q_q     <= q_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign q         = q_q;
  assign level     = level_q;
  assign empty     = is_empty;
  assign full      = is_full;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_bf_loop_stack.sv
// Directed and model-based checks of bf_loop_stack at WIDTH=11, DEPTH=3 (capacity 8).
module tb_bf_loop_stack;

  localparam int W   = 11;
  localparam int D   = 3;
  localparam int CAP = 8;

  logic         clk = 1'b0;
  logic         reset, push, pop, flush, err_clr;
  logic [W-1:0] d;
  logic [W-1:0] q;
  logic         empty, full, overflow, underflow;
  logic [D:0]   level;

  int errors = 0;
  int checks = 0;

  bf_loop_stack #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .d         (d),
    .push      (push),
    .pop       (pop),
    .flush     (flush),
    .err_clr   (err_clr),
    .q         (q),
    .empty     (empty),
    .full      (full),
    .level     (level),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  // One command cycle; outputs are sampled 1 time unit after the edge.
  task automatic drive(input logic pu, input logic po, input logic fl,
                       input logic ec, input logic rs, input logic [W-1:0] dv);
    push = pu; pop = po; flush = fl; err_clr = ec; reset = rs; d = dv;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; flush = 1'b0; err_clr = 1'b0; reset = 1'b0; d = '0;
  endtask

  task automatic test_reset;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 11'h000);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 11'h000);
    checks++;
    if ({q, level, empty, full, overflow, underflow} !== {11'h000, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset: q=%h level=%0d e=%b f=%b o=%b u=%b, want q=000 level=0 e=1 f=0 o=0 u=0",
               q, level, empty, full, overflow, underflow);
    end
  endtask

  task automatic test_fill_drain;
    for (int i = 1; i <= CAP; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, W'(i));
      checks++;
      if (q !== W'(i) || level !== 4'(i)) begin
        errors++;
        $display("FAIL fill: q=%h level=%0d, want q=%h level=%0d", q, level, W'(i), i);
      end
    end
    checks++;
    if (full !== 1'b1 || overflow !== 1'b0 || empty !== 1'b0) begin
      errors++;
      $display("FAIL full_flags: full=%b ovf=%b empty=%b, want 1 0 0", full, overflow, empty);
    end
    for (int k = 1; k <= CAP; k++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'h000);
      checks++;
      if (q !== W'(CAP - k) || level !== 4'(CAP - k)) begin
        errors++;
        $display("FAIL drain: q=%h level=%0d, want q=%h level=%0d", q, level, W'(CAP - k), CAP - k);
      end
    end
    checks++;
    if (empty !== 1'b1 || full !== 1'b0 || underflow !== 1'b0) begin
      errors++;
      $display("FAIL empty_flags: empty=%b full=%b unf=%b, want 1 0 0", empty, full, underflow);
    end
  endtask

  task automatic test_overflow;
    for (int i = 1; i <= CAP; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, W'(i));
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'h7FF);
    checks++;
    if (q !== 11'h008 || level !== 4'd8 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow: q=%h level=%0d ovf=%b, want 008 8 1", q, level, overflow);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 11'h000);
    checks++;
    if (overflow !== 1'b0 || q !== 11'h008) begin
      errors++;
      $display("FAIL ovf_clear: ovf=%b q=%h, want 0 008", overflow, q);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 11'h123);
    checks++;
    if (q !== 11'h123 || level !== 4'd8 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL replace_full: q=%h level=%0d ovf=%b, want 123 8 0", q, level, overflow);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'h000);
    checks++;
    if (q !== 11'h007 || level !== 4'd7) begin
      errors++;
      $display("FAIL pop_after_repl: q=%h level=%0d, want 007 7", q, level);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 11'h000);
  endtask

  task automatic test_underflow;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'h000);
    checks++;
    if (underflow !== 1'b1 || q !== 11'h000 || level !== 4'd0) begin
      errors++;
      $display("FAIL underflow: unf=%b q=%h level=%0d, want 1 000 0", underflow, q, level);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 11'h000);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 11'h055);
    checks++;
    if (q !== 11'h055 || level !== 4'd1 || underflow !== 1'b0) begin
      errors++;
      $display("FAIL replace_empty: q=%h level=%0d unf=%b, want 055 1 0", q, level, underflow);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'h000);
    checks++;
    if (q !== 11'h000 || level !== 4'd0 || underflow !== 1'b0) begin
      errors++;
      $display("FAIL pop_last: q=%h level=%0d unf=%b, want 000 0 0", q, level, underflow);
    end
  endtask

  task automatic test_flush;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'h010);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'h020);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'h030);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 11'h000);
    checks++;
    if (q !== 11'h000 || level !== 4'd0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL flush: q=%h level=%0d empty=%b, want 000 0 1", q, level, empty);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'h040);
    checks++;
    if (q !== 11'h040 || level !== 4'd1) begin
      errors++;
      $display("FAIL push_after_flush: q=%h level=%0d, want 040 1", q, level);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'h000);
    checks++;
    if (q !== 11'h000 || level !== 4'd0) begin
      errors++;
      $display("FAIL pop_after_flush: q=%h level=%0d, want 000 0", q, level);
    end
    // flush outranks a pop on an empty stack, so no underflow
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 11'h000);
    checks++;
    if (underflow !== 1'b0 || level !== 4'd0) begin
      errors++;
      $display("FAIL flush_pop: unf=%b level=%0d, want 0 0", underflow, level);
    end
  endtask

  task automatic test_err_set_wins;
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 11'h000);
    checks++;
    if (underflow !== 1'b1) begin
      errors++;
      $display("FAIL set_wins: unf=%b, want 1", underflow);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 11'h000);
    checks++;
    if (underflow !== 1'b1) begin
      errors++;
      $display("FAIL flush_keeps_flag: unf=%b, want 1", underflow);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 11'h000);
    checks++;
    if (underflow !== 1'b0) begin
      errors++;
      $display("FAIL err_clr: unf=%b, want 0", underflow);
    end
  endtask

  task automatic test_reset_with_push;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'h001);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 11'h3AA);
    checks++;
    if (q !== 11'h000 || level !== 4'd0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL reset_push: q=%h level=%0d empty=%b, want 000 0 1", q, level, empty);
    end
  endtask

  task automatic test_random;
    logic [W-1:0] mdl[$];
    logic         m_ovf, m_unf, pu, po, fl, ec;
    logic [W-1:0] dv, exp_q;
    int           pct;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      pct = ((i / 400) % 2 == 0) ? 70 : 30;
      pu  = ($urandom_range(0, 99) < pct);
      po  = ($urandom_range(0, 99) < 100 - pct);
      fl  = ($urandom_range(0, 99) < 3);
      ec  = ($urandom_range(0, 99) < 10);
      dv  = W'($urandom);
      if (ec) begin
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end
      if (fl) begin
        mdl.delete();
      end else if (pu && !po) begin
        if (mdl.size() == CAP) m_ovf = 1'b1;
        else mdl.push_back(dv);
      end else if (po && !pu) begin
        if (mdl.size() == 0) m_unf = 1'b1;
        else void'(mdl.pop_back());
      end else if (pu && po) begin
        if (mdl.size() == 0) mdl.push_back(dv);
        else mdl[mdl.size() - 1] = dv;
      end
      exp_q = (mdl.size() == 0) ? 11'h000 : mdl[mdl.size() - 1];
      drive(pu, po, fl, ec, 1'b0, dv);
      checks++;
      if (q !== exp_q || level !== 4'(mdl.size()) || empty !== (mdl.size() == 0) ||
          full !== (mdl.size() == CAP) || overflow !== m_ovf || underflow !== m_unf) begin
        errors++;
        $display("FAIL random[%0d]: q=%h lvl=%0d e=%b f=%b o=%b u=%b, want q=%h lvl=%0d o=%b u=%b",
                 i, q, level, empty, full, overflow, underflow, exp_q, mdl.size(), m_ovf, m_unf);
      end
    end
  endtask

  initial begin
    reset = 1'b1; push = 1'b0; pop = 1'b0; flush = 1'b0; err_clr = 1'b0; d = '0;
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_flush();
    test_err_set_wins();
    test_reset_with_push();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
